cmp_arbiter: RTL and testbench

Shares one 4-bit magnitude comparator between four requesters. Each requester presents an operand pair and raises a request. The arbiter grants one requester at a time, latches its operands and runs them through the comparator. It then returns the registered less/equal/greater result, tagged with the requester index. It sits between the comparator datapath and the client blocks that need compare results.

---
 rtl/cmp_arbiter.sv | 93 +++++++++
 tb/tb_cmp_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// Four-requester arbiter sharing one 4-bit magnitude comparator (IDLE -> CMP -> RSP).
// Define CMP_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module cmp_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] DinA_bus,
  input  logic [15:0] DinB_bus,
  output logic [3:0]  gnt,
  output logic        busy,
  output logic        rsp_valid,
  output logic [1:0]  rsp_id,
  output logic        less,
  output logic        equal,
  output logic        greater
);

  typedef enum logic [1:0] {StIdle, StCmp, StRsp} state_e;

  state_e     state_q;
  logic [3:0] op_a_q;
  logic [3:0] op_b_q;
  logic [1:0] win;

`ifdef CMP_ARB_RR_EN
  logic [1:0] ptr_q;

  // Walk from the farthest offset down so the requester nearest the pointer wins.
  always_comb begin
    win = '0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (state_q == StIdle && req != 4'b0000) begin
      ptr_q <= win + 2'd1;
    end
  end
`else
  always_comb begin
    win = '0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) win = 2'(k);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_a_q    <= '0;
      op_b_q    <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      less      <= 1'b0;
      equal     <= 1'b0;
      greater   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req != 4'b0000) begin
            op_a_q  <= DinA_bus[{win, 2'b00} +: 4];
            op_b_q  <= DinB_bus[{win, 2'b00} +: 4];
            rsp_id  <= win;
            gnt     <= 4'b0001 << win;
            state_q <= StCmp;
          end
        end
        StCmp: begin
          less      <= op_a_q < op_b_q;
          equal     <= op_a_q == op_b_q;
          greater   <= op_a_q > op_b_q;
          rsp_valid <= 1'b1;
          gnt       <= '0;
          state_q   <= StRsp;
        end
        StRsp: begin
          rsp_valid <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: expected responses are queued as requests are driven
// and popped when rsp_valid strobes.
module tb_cmp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] DinA_bus;
  logic [15:0] DinB_bus;
  logic [3:0]  gnt;
  logic        busy;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic        less;
  logic        equal;
  logic        greater;

  typedef struct packed {
    logic [1:0] id;
    logic       lt;
    logic       eq;
    logic       gt;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  cmp_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .DinA_bus  (DinA_bus),
    .DinB_bus  (DinB_bus),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .less      (less),
    .equal     (equal),
    .greater   (greater)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic rsp_t mk_rsp(input logic [1:0] id, input logic [3:0] a, input logic [3:0] b);
    rsp_t t;
    t.id = id;
    t.lt = (a < b);
    t.eq = (a == b);
    t.gt = (a > b);
    return t;
  endfunction

  task automatic set_ops(input int id, input logic [3:0] a, input logic [3:0] b);
    DinA_bus[id*4 +: 4] = a;
    DinB_bus[id*4 +: 4] = b;
  endtask

  // Returns at the negedge inside the grant cycle, or flags a timeout.
  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt != 4'b0000) begin
        ok = 1'b1;
        return;
      end
    end
    check("gnt_timeout", 0, 1);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_valid"}, 32'(rsp_valid), 0);
    check({tag, "_res"}, 32'({rsp_id, less, equal, greater}), 0);
  endtask

  task automatic txn(input int id, input logic [3:0] a, input logic [3:0] b, input bit scramble);
    bit ok;
    @(negedge clk);
    set_ops(id, a, b);
    req = 4'b0001 << id;
    exp_q.push_back(mk_rsp(2'(id), a, b));
    wait_gnt(ok);
    if (!ok) return;
    check("gnt_onehot", 32'(gnt), 32'(4'b0001 << id));
    req = 4'b0000;
    if (scramble) set_ops(id, b, a);
    @(negedge clk);
    check("lat_valid", 32'(rsp_valid), 1);
    check("gnt_1cyc", 32'(gnt), 0);
    @(negedge clk);
    check("valid_1cyc", 32'(rsp_valid), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  task automatic burst(input logic [3:0] r, input int n);
    logic [3:0] ta[4];
    logic [3:0] tb[4];
    int         order[$];
    int         last;
    bit         ok;
    ta = '{4'd2, 4'd9, 4'd4, 4'd15};
    tb = '{4'd8, 4'd9, 4'd1, 4'd0};
    for (int k = 0; k < n; k++) begin
`ifdef CMP_ARB_RR_EN
      order.push_back(k % 4);
`else
      order.push_back(1);
`endif
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_ops(i, ta[i], tb[i]);
    foreach (order[k]) exp_q.push_back(mk_rsp(2'(order[k]), ta[order[k]], tb[order[k]]));
    req  = r;
    last = 0;
    for (int k = 0; k < n; k++) begin
      wait_gnt(ok);
      if (!ok) begin
        req = 4'b0000;
        return;
      end
      check("burst_gnt", 32'(gnt), 32'(4'b0001 << order[k]));
      if (k > 0) check("burst_gap", 32'(cyc - last), 3);
      last = cyc;
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);
    check("burst_idle", 32'(busy), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp", 32'({rsp_id, less, equal, greater}), 32'(mon_e));
      end
    end
  end

  initial begin
    bit ok;
    rst      = 1'b1;
    req      = 4'b0000;
    DinA_bus = '0;
    DinB_bus = '0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;

    txn(0, 4'd5, 4'd9, 1'b0);
    txn(2, 4'd7, 4'd7, 1'b0);
    txn(2, 4'd15, 4'd0, 1'b0);
    txn(0, 4'd3, 4'd12, 1'b1);
    txn(3, 4'd0, 4'd15, 1'b0);
    txn(1, 4'd15, 4'd15, 1'b0);

    // Reset while the transaction is in CMP: it must vanish without a response.
    @(negedge clk);
    set_ops(0, 4'd1, 4'd2);
    req = 4'b0001;
    wait_gnt(ok);
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    check_idle_zero("midrst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_novalid", 32'(rsp_valid), 0);

`ifdef CMP_ARB_RR_EN
    burst(4'b1111, 6);
`else
    burst(4'b1110, 4);
`endif

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
